// File: rtl/unified_mem_arbiter.sv
// Shared single-port memory arbiter for the IF and MEM stages of the pipeline.
// Data accesses win over fetches; each access is issue -> wait -> done, and a
// global stall holds the pipeline until every access pending this cycle has
// completed.
module unified_mem_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state, state_nxt;
  logic       sel;      // 1: data access in flight, 0: instruction fetch
  logic       we_l;     // write flag of the access in flight
  logic [3:0] cnt;
  logic       dm_done, if_done;
  logic       dm_req, dm_pend, if_pend, wait_last;

  assign dm_req    = dm_read | dm_write;
  assign dm_pend   = dm_req & ~dm_done;
  assign if_pend   = if_req & ~if_done;
  assign wait_last = (state == WAIT) && (cnt == 4'd1);

  // Stall until each requester has either been served this cycle or is acked now.
  assign stall = ~rst & ((dm_pend & ~dm_ack) | (if_pend & ~if_ack));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: one access at a time, DONE always returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dm_pend || if_pend) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered memory strobes, latency counter, read capture and ack pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= 1'b0;
      we_l      <= 1'b0;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          // Strobes are loaded here so they are live during the ISSUE cycle.
          if (dm_pend) begin
            sel       <= 1'b1;
            we_l      <= dm_write;
            mem_en    <= 1'b1;
            mem_we    <= dm_write;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_write ? dm_wdata : '0;
          end else if (if_pend) begin
            sel       <= 1'b0;
            we_l      <= 1'b0;
            mem_en    <= 1'b1;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end
        ISSUE: cnt <= 4'(MEM_LATENCY);
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (wait_last) begin
            if (sel) begin
              if (!we_l) dm_rdata <= mem_rdata;
              dm_ack <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Served flags: remember a completed access until the pipeline advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_done <= 1'b0;
      if_done <= 1'b0;
    end else if (!stall) begin
      dm_done <= 1'b0;
      if_done <= 1'b0;
    end else if (state == DONE) begin
      if (sel) dm_done <= 1'b1;
      else     if_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a latency-2 instance and a latency-1
// instance, each with a small behavioural memory returning data exactly at E+L.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // latency-2 instance signals
  logic        if_req, dm_read, dm_write;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, dm_ack, mem_en, mem_we, stall;

  // latency-1 instance signals
  logic        if1_req;
  logic [31:0] if1_addr;
  logic        dm1_read, dm1_write;
  logic [31:0] dm1_addr, dm1_wdata;
  logic [31:0] if1_rdata, dm1_rdata, mem1_addr, mem1_wdata, mem1_rdata;
  logic        if1_ack, dm1_ack, mem1_en, mem1_we, stall1;

  int n_chk = 0;
  int n_fail = 0;

  unified_mem_arbiter #(.MEM_LATENCY(2), .ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  unified_mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if1_req), .if_addr(if1_addr), .if_rdata(if1_rdata), .if_ack(if1_ack),
    .dm_read(dm1_read), .dm_write(dm1_write), .dm_addr(dm1_addr), .dm_wdata(dm1_wdata),
    .dm_rdata(dm1_rdata), .dm_ack(dm1_ack),
    .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
    .mem_rdata(mem1_rdata), .stall(stall1)
  );

  // Behavioural memory: word i holds 0x1000_0000+i except two marked words
  logic [31:0] mem [0:31];
  logic [1:0]  p2_v;
  logic [31:0] p2_a [0:1];
  logic        p1_v;
  logic [31:0] p1_a;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)      return 32'h1234_5678;
    else if (i == 8) return 32'hCAFE_0020;
    else             return 32'h1000_0000 + 32'(i);
  endfunction

  // Memory array and read-return pipelines; data visible only in cycle E+L
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr[6:2]] <= mem_wdata;
    end
    p2_v[0] <= mem_en & ~mem_we;
    p2_a[0] <= mem_addr;
    p2_v[1] <= p2_v[0];
    p2_a[1] <= p2_a[0];
    p1_v    <= mem1_en & ~mem1_we;
    p1_a    <= mem1_addr;
  end

  assign mem_rdata  = p2_v[1] ? mem[p2_a[1][6:2]] : 32'hBAD0_BAD0;
  assign mem1_rdata = p1_v    ? mem[p1_a[6:2]]    : 32'hBAD1_BAD1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to the middle of the next cycle
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = 0; dm_read = 1; dm_write = 0; dm_addr = 0; dm_wdata = 0;
    if1_req = 0; if1_addr = 0; dm1_read = 0; dm1_write = 0; dm1_addr = 0; dm1_wdata = 0;

    // reset: outputs zero, stall forced low even with a request present
    cyc();
    chk("rst_stall", stall, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_dm_ack", dm_ack, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(negedge clk); rst = 0; dm_read = 0;

    // --- data read 0x10 ---
    @(negedge clk); dm_read = 1; dm_addr = 32'h10; #1;
    chk("rd_c0_stall", stall, 1);
    chk("rd_c0_en", mem_en, 0);
    cyc();
    chk("rd_c1_en", mem_en, 1);
    chk("rd_c1_we", mem_we, 0);
    chk("rd_c1_addr", mem_addr, 32'h10);
    chk("rd_c1_stall", stall, 1);
    cyc();
    chk("rd_c2_en", mem_en, 0);
    chk("rd_c2_stall", stall, 1);
    cyc();
    chk("rd_c3_stall", stall, 1);
    chk("rd_c3_ack", dm_ack, 0);
    cyc();
    chk("rd_c4_ack", dm_ack, 1);
    chk("rd_c4_rdata", dm_rdata, 32'h1234_5678);
    chk("rd_c4_stall", stall, 0);
    @(negedge clk); dm_read = 0; #1;
    chk("rd_c5_ack", dm_ack, 0);
    chk("rd_c5_en", mem_en, 0);

    // --- data write 0x40 ---
    @(negedge clk); dm_write = 1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF; #1;
    chk("wr_c0_stall", stall, 1);
    cyc();
    chk("wr_c1_en", mem_en, 1);
    chk("wr_c1_we", mem_we, 1);
    chk("wr_c1_addr", mem_addr, 32'h40);
    chk("wr_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    chk("wr_c2_we", mem_we, 0);
    cyc();
    cyc();
    chk("wr_c4_ack", dm_ack, 1);
    chk("wr_c4_rdata_kept", dm_rdata, 32'h1234_5678);
    chk("wr_c4_stall", stall, 0);
    @(negedge clk); dm_write = 0; dm_wdata = 0; #1;

    // --- simultaneous data read 0x20 and fetch 0x0: data first ---
    @(negedge clk); dm_read = 1; dm_addr = 32'h20; if_req = 1; if_addr = 32'h0; #1;
    chk("both_c0_stall", stall, 1);
    cyc();
    chk("both_c1_en", mem_en, 1);
    chk("both_c1_addr", mem_addr, 32'h20);
    cyc(); cyc(); cyc();
    chk("both_c4_dm_ack", dm_ack, 1);
    chk("both_c4_rdata", dm_rdata, 32'hCAFE_0020);
    chk("both_c4_stall", stall, 1);
    cyc();
    chk("both_c5_stall", stall, 1);
    chk("both_c5_en", mem_en, 0);
    cyc();
    chk("both_c6_en", mem_en, 1);
    chk("both_c6_addr", mem_addr, 32'h0);
    cyc(); cyc();
    chk("both_c8_stall", stall, 1);
    chk("both_c8_if_ack", if_ack, 0);
    cyc();
    chk("both_c9_if_ack", if_ack, 1);
    chk("both_c9_if_rdata", if_rdata, 32'h1000_0000);
    chk("both_c9_dm_ack", dm_ack, 0);
    chk("both_c9_stall", stall, 0);
    @(negedge clk); dm_read = 0; if_req = 0; #1;
    chk("both_c10_en", mem_en, 0);
    chk("both_c10_if_ack", if_ack, 0);

    // --- continuous fetch stream 0x0, 0x4, 0x8 ---
    @(negedge clk); if_req = 1; if_addr = 32'h0; #1;
    cyc();
    chk("fs_c1_addr", mem_addr, 32'h0);
    chk("fs_c1_en", mem_en, 1);
    cyc(); cyc(); cyc();
    chk("fs_c4_ack", if_ack, 1);
    chk("fs_c4_rdata", if_rdata, 32'h1000_0000);
    @(negedge clk); if_addr = 32'h4; #1;
    chk("fs_c5_stall", stall, 1);
    chk("fs_c5_ack", if_ack, 0);
    cyc();
    chk("fs_c6_addr", mem_addr, 32'h4);
    cyc(); cyc(); cyc();
    chk("fs_c9_ack", if_ack, 1);
    chk("fs_c9_rdata", if_rdata, 32'h1000_0001);
    @(negedge clk); if_addr = 32'h8; #1;
    cyc();
    chk("fs_c11_addr", mem_addr, 32'h8);
    chk("fs_c11_en", mem_en, 1);
    cyc(); cyc();
    chk("fs_c13_ack", if_ack, 0);
    cyc();
    chk("fs_c14_ack", if_ack, 1);
    chk("fs_c14_rdata", if_rdata, 32'h1000_0002);
    @(negedge clk); if_req = 0; if_addr = 0; #1;

    // --- reset in the middle of a read ---
    @(negedge clk); dm_read = 1; dm_addr = 32'h10; #1;
    cyc();
    chk("rr_c1_en", mem_en, 1);
    @(negedge clk); rst = 1; dm_read = 0; #1;
    chk("rr_c2_stall", stall, 0);
    chk("rr_c2_en", mem_en, 0);
    cyc();
    chk("rr_c3_dm_ack", dm_ack, 0);
    chk("rr_c3_dm_rdata", dm_rdata, 0);
    chk("rr_c3_if_rdata", if_rdata, 0);
    chk("rr_c3_mem_addr", mem_addr, 0);
    @(negedge clk); rst = 0; #1;
    chk("rr_c4_dm_ack", dm_ack, 0);
    @(negedge clk); dm_read = 1; dm_addr = 32'h08; #1;
    chk("rr_c5_stall", stall, 1);
    chk("rr_c5_en", mem_en, 0);
    cyc();
    chk("rr_c6_en", mem_en, 1);
    chk("rr_c6_addr", mem_addr, 32'h08);
    cyc();
    chk("rr_c7_dm_ack", dm_ack, 0);
    cyc();
    chk("rr_c8_dm_ack", dm_ack, 0);
    cyc();
    chk("rr_c9_dm_ack", dm_ack, 1);
    chk("rr_c9_rdata", dm_rdata, 32'h1000_0002);
    @(negedge clk); dm_read = 0; #1;

    // --- latency-1 instance fetch 0x4 ---
    @(negedge clk); if1_req = 1; if1_addr = 32'h4; #1;
    chk("l1_c0_stall", stall1, 1);
    cyc();
    chk("l1_c1_en", mem1_en, 1);
    chk("l1_c1_addr", mem1_addr, 32'h4);
    cyc();
    chk("l1_c2_en", mem1_en, 0);
    chk("l1_c2_ack", if1_ack, 0);
    chk("l1_c2_stall", stall1, 1);
    cyc();
    chk("l1_c3_ack", if1_ack, 1);
    chk("l1_c3_rdata", if1_rdata, 32'h1000_0001);
    chk("l1_c3_stall", stall1, 0);
    @(negedge clk); if1_req = 0; #1;
    chk("l1_c4_ack", if1_ack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
